// File: rtl/mmio_responder_pkg.sv
// Shared header: RISC-V opcodes plus the MMIO base and register offsets.
package mmio_responder_pkg;

    // RISC-V base opcodes (inst[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // MMIO window: addr[31:8] selects the block.
    localparam logic [23:0] MMIO_BASE = 24'hFFFFFC;

    // Word offsets (addr[7:2]) of the register map.
    typedef enum logic [5:0] {
        OffSw       = 6'h00,  // byte offset 0x00
        OffBtn      = 6'h01,  // byte offset 0x04
        OffLed      = 6'h04,  // byte offset 0x10
        OffTimer    = 6'h08,  // byte offset 0x20
        OffTimerClr = 6'h09   // byte offset 0x24
    } mmio_off_e;

    function automatic logic mmio_hit(input logic [31:0] a);
        return a[31:8] == MMIO_BASE;
    endfunction

endpackage

// File: rtl/mmio_responder_debouncer.sv
// Button synchronizer plus debounce counter with a rising-edge strobe.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic                   level_q;
    logic                   synced;
    logic                   differ;
    logic                   done;

    assign synced = sync_q[SYNC_STAGES-1];
    assign differ = synced != level_q;
    assign done   = cnt_q == CntW'(DEBOUNCE_CYCLES - 1);

    // Same-cycle strobe so the caller can act at the edge where the level rises.
    assign rise  = differ & done & synced;
    assign level = level_q;

    // Synchronize, then count consecutive differing cycles; agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (differ) begin
                if (done) begin
                    level_q <= synced;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO slave exposing switches, a debounced button, LEDs and a cycle timer.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led
);

    logic [15:0] sw_sync_q [SYNC_STAGES];
    logic [15:0] sw_s;
    logic        btn_level;
    logic        btn_rise;
    logic        flag_q;
    logic [15:0] led_q;
    logic [31:0] timer_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;

    logic        hit;
    logic [5:0]  off;
    logic        wr_en;
    logic        rd_en;
    logic        btn_rd;
    logic [31:0] rd_mux;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign sw_s   = sw_sync_q[SYNC_STAGES-1];
    assign hit    = mmio_hit(addr);
    assign off    = addr[7:2];
    assign wr_en  = ioWrite & hit;
    // A simultaneous write wins; the read is dropped entirely.
    assign rd_en  = ioRead & ~ioWrite;
    assign btn_rd = rd_en & hit & (off == OffBtn);

    // Read data mux; anything outside the window or map reads as zero.
    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (off)
                OffSw:    rd_mux = {16'b0, sw_s};
                OffBtn:   rd_mux = {30'b0, flag_q, btn_level};
                OffLed:   rd_mux = {16'b0, led_q};
                OffTimer: rd_mux = timer_q;
                default:  rd_mux = '0;
            endcase
        end
    end

    // Register file, timer, sticky flag, switch synchronizer and read response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= '0;
            end
            flag_q   <= 1'b0;
            led_q    <= '0;
            timer_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            sw_sync_q[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end

            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_mux;
            end

            if (wr_en && off == OffLed) begin
                led_q <= wdata[15:0];
            end

            if (wr_en && off == OffTimerClr) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end

            // A press landing on the same edge as a clearing read is kept.
            if (btn_rise) begin
                flag_q <= 1'b1;
            end else if (btn_rd) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign led    = led_q;

endmodule
